conv_tile_scheduler: RTL and testbench
======================================

# conv_tile_scheduler

Sequences one convolution layer on the NPU conv engine by splitting it into output-channel × output-row tiles. Latches the layer configuration on `start`, derives output geometry, and issues one engine start per tile with the tile's channel base, row base, row count and output-memory base address. It waits for the engine's completion handshake before advancing, then reports layer completion. Sits between the host/top-level control (`start`/`done`) and the conv engine datapath.

## Interface
- `OC_TILE`, 8, output channels computed per engine pass (power of two, 1..64)
- `ROW_TILE`, 4, output rows computed per engine pass (1..32)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; accepted only in IDLE
- `K`, `IC`, `IMG_H`, `IMG_W`, `OC`, `STRIDE`  in  3/14/6/6/8/3  layer config; sampled on accepted `start`
- `busy`  out  1  high from accepted `start` until `done` cycle inclusive
- `done`  out  1  one-cycle pulse at layer end (also on config error)
- `err`  out  1  one-cycle pulse, coincident with `done`, for invalid config
- `eng_start`  out  1  one-cycle pulse per tile
- `eng_done`  in  1  one-cycle pulse from engine, tile finished
- `tile_oc_base`  out  8  first output channel of tile
- `tile_oc_cnt`  out  7  output channels in tile
- `tile_row_base`  out  6  first output row of tile
- `tile_rows`  out  6  output rows in tile
- `tile_out_base`  out  18  output-memory word address of tile's first element
- `tiles_done`  out  12  tiles completed in current layer

## Operation
- States: IDLE, CALC, ISSUE, WAIT, NEXT, FIN.
- IDLE: `start`=1 latches config → CALC. `start` in any other state ignored.
- CALC (1 cycle): OH = ((IMG_H−K) >> (STRIDE==2)) + 1, OW likewise with IMG_W; PLANE = OH×OW (12-bit product). Invalid if K=0, K>IMG_H, K>IMG_W, OC=0, IC=0, or STRIDE∉{1,2}: → FIN with error flag. Else zero oc_base, row_base, tiles_done → ISSUE.
- Tile fields: tile_rows = min(ROW_TILE, OH−row_base); tile_oc_cnt = min(OC_TILE, OC−oc_base); tile_out_base = oc_base×PLANE + row_base×OW (channel-major, row-major within plane), maintained incrementally (plane accumulator += OC_TILE×PLANE per OC tile; row offset += ROW_TILE×OW per row tile).
- ISSUE (1 cycle): `eng_start`=1 → WAIT. Tile fields valid from ISSUE and held stable until leaving WAIT.
- WAIT: hold until `eng_done`=1 → NEXT; `tiles_done`++ on that cycle.
- NEXT: row tiles inner loop, OC tiles outer. If row_base+ROW_TILE < OH: row_base += ROW_TILE → ISSUE. Else row_base=0; if oc_base+OC_TILE < OC: oc_base += OC_TILE → ISSUE; else → FIN.
- FIN (1 cycle): `done`=1, `err`=error flag → IDLE.
- `eng_done` outside WAIT ignored. `eng_done` and `start` same cycle in WAIT: `start` ignored.
- Reset mid-layer: next cycle IDLE, all counters and outputs at reset values; no further `eng_start`; engine reset is the top level's responsibility.

## Timing
- Reset values: `busy`,`done`,`err`,`eng_start`=0; all tile fields and `tiles_done`=0.
- `start` sampled at edge t → CALC t+1 → first `eng_start` high in cycle t+2.
- `eng_done` sampled at edge u → NEXT u+1 → next `eng_start` in cycle u+2, or `done` in cycle u+2 after last tile.
- Error path: `start` at t → `done`=`err`=1 in cycle t+2, zero `eng_start` pulses.
- `busy` low in cycle after `done`; new `start` accepted from that cycle.
- All outputs registered.

## Test plan
- K=3, IC=8, 32×32, OC=16, STRIDE=1, defaults, engine acks 5 cycles after each start → OH=OW=30, 16 `eng_start` pulses; tile 7 (row 28): rows=2, out_base=840; tile 8: oc_base=8, row 0, out_base=7200; `tiles_done`=16, one `done`.
- K=1, IC=16, 32×32, OC=32, STRIDE=1 → OH=32, 32 tiles, all rows=4, oc_cnt=8; last out_base=24×1024+28×32=25472.
- K=3, 32×32, OC=12, STRIDE=2 → OH=15; row tiles 4,4,4,3; second OC tile oc_cnt=4, out_base=8×225=1800; 8 tiles.
- Invalid configs (K=0; K=7 with IMG_H=6; STRIDE=3; OC=0) → `done`&`err` 2 cycles after `start`, no `eng_start`.
- Spurious `eng_done` in IDLE/ISSUE and repeated `start` during WAIT → no state change; tile sequence unchanged.
- Assert `rst` during WAIT of tile 3, release, restart → all outputs 0 during reset; restarted layer issues tile 0 with out_base=0, completes normally.

Source files
------------

// File: rtl/conv_tile_scheduler.sv
// Convolution layer tile sequencer: walks output-channel x output-row tiles and
// hands each tile to the conv engine, one start/done handshake per tile.
module conv_tile_scheduler #(
    parameter int unsigned OC_TILE  = 8,
    parameter int unsigned ROW_TILE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  K,
    input  logic [13:0] IC,
    input  logic [5:0]  IMG_H,
    input  logic [5:0]  IMG_W,
    input  logic [7:0]  OC,
    input  logic [2:0]  STRIDE,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        eng_start,
    input  logic        eng_done,
    output logic [7:0]  tile_oc_base,
    output logic [6:0]  tile_oc_cnt,
    output logic [5:0]  tile_row_base,
    output logic [5:0]  tile_rows,
    output logic [17:0] tile_out_base,
    output logic [11:0] tiles_done
);

    localparam logic [6:0] RowTile7 = 7'(ROW_TILE);
    localparam logic [5:0] RowTile6 = 6'(ROW_TILE);
    localparam logic [8:0] OcTile9  = 9'(OC_TILE);
    localparam logic [7:0] OcTile8  = 8'(OC_TILE);

    typedef enum logic [2:0] {StIdle, StCalc, StIssue, StWait, StNext, StFin} state_e;
    state_e state_q, state_d;

    logic [2:0]  k_q, stride_q;
    logic [13:0] ic_q;
    logic [5:0]  img_h_q, img_w_q, oh_q, ow_q, row_base_q, row_base_n;
    logic [7:0]  oc_q, oc_base_q, oc_base_n;
    logic [11:0] plane_q;
    logic [17:0] plane_acc_q, plane_acc_n, row_off_q, row_off_n;
    logic        err_q;

    logic [5:0]  dh, dw, oh_c, ow_c, oh_cur, rem_rows, rows_n;
    logic [11:0] plane_c;
    logic [7:0]  rem_oc, oc_cnt_n;
    logic [17:0] row_step, oc_step;
    logic        cfg_bad, row_more, oc_more, err_n;
    logic        busy_d, done_d, err_d, eng_start_d;

    // Output geometry from the latched config; only meaningful while in CALC.
    always_comb begin
        dh       = img_h_q - {3'd0, k_q};
        dw       = img_w_q - {3'd0, k_q};
        oh_c     = ((stride_q == 3'd2) ? (dh >> 1) : dh) + 6'd1;
        ow_c     = ((stride_q == 3'd2) ? (dw >> 1) : dw) + 6'd1;
        plane_c  = {6'd0, oh_c} * {6'd0, ow_c};
        cfg_bad  = (k_q == 3'd0) || ({3'd0, k_q} > img_h_q) || ({3'd0, k_q} > img_w_q) ||
                   (oc_q == 8'd0) || (ic_q == 14'd0) ||
                   ((stride_q != 3'd1) && (stride_q != 3'd2));
        oh_cur   = (state_q == StCalc) ? oh_c : oh_q;
        err_n    = (state_q == StCalc) ? cfg_bad : err_q;
        row_step = 18'(ROW_TILE) * {12'd0, ow_q};
        oc_step  = 18'(OC_TILE) * {6'd0, plane_q};
        row_more = ({1'b0, row_base_q} + RowTile7) < {1'b0, oh_q};
        oc_more  = ({1'b0, oc_base_q} + OcTile9) < {1'b0, oc_q};
    end

    // Tile counters: rows are the inner loop, channel groups the outer loop.
    always_comb begin
        row_base_n  = row_base_q;
        oc_base_n   = oc_base_q;
        plane_acc_n = plane_acc_q;
        row_off_n   = row_off_q;
        if (state_q == StCalc) begin
            row_base_n  = '0;
            oc_base_n   = '0;
            plane_acc_n = '0;
            row_off_n   = '0;
        end else if (state_q == StNext) begin
            if (row_more) begin
                row_base_n = row_base_q + RowTile6;
                row_off_n  = row_off_q + row_step;
            end else begin
                row_base_n = '0;
                row_off_n  = '0;
                if (oc_more) begin
                    oc_base_n   = oc_base_q + OcTile8;
                    plane_acc_n = plane_acc_q + oc_step;
                end
            end
        end
        rem_rows = oh_cur - row_base_n;
        rows_n   = (rem_rows > RowTile6) ? RowTile6 : rem_rows;
        rem_oc   = oc_q - oc_base_n;
        oc_cnt_n = (rem_oc > OcTile8) ? OcTile8 : rem_oc;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  state_d = cfg_bad ? StFin : StIssue;
            StIssue: state_d = StWait;
            StWait:  if (eng_done) state_d = StNext;
            StNext:  state_d = (row_more || oc_more) ? StIssue : StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StFin);
        err_d       = (state_d == StFin) && err_n;
        eng_start_d = (state_d == StIssue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            k_q           <= '0;
            ic_q          <= '0;
            img_h_q       <= '0;
            img_w_q       <= '0;
            oc_q          <= '0;
            stride_q      <= '0;
            oh_q          <= '0;
            ow_q          <= '0;
            plane_q       <= '0;
            err_q         <= 1'b0;
            row_base_q    <= '0;
            oc_base_q     <= '0;
            plane_acc_q   <= '0;
            row_off_q     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            eng_start     <= 1'b0;
            tile_oc_base  <= '0;
            tile_oc_cnt   <= '0;
            tile_row_base <= '0;
            tile_rows     <= '0;
            tile_out_base <= '0;
            tiles_done    <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            eng_start   <= eng_start_d;
            row_base_q  <= row_base_n;
            oc_base_q   <= oc_base_n;
            plane_acc_q <= plane_acc_n;
            row_off_q   <= row_off_n;
            if ((state_q == StIdle) && start) begin
                k_q      <= K;
                ic_q     <= IC;
                img_h_q  <= IMG_H;
                img_w_q  <= IMG_W;
                oc_q     <= OC;
                stride_q <= STRIDE;
            end
            if (state_q == StCalc) begin
                oh_q    <= oh_c;
                ow_q    <= ow_c;
                plane_q <= plane_c;
                err_q   <= cfg_bad;
                if (!cfg_bad) tiles_done <= '0;
            end
            if ((state_q == StWait) && eng_done) tiles_done <= tiles_done + 12'd1;
            if (state_d == StIssue) begin
                tile_oc_base  <= oc_base_n;
                tile_oc_cnt   <= oc_cnt_n[6:0];
                tile_row_base <= row_base_n;
                tile_rows     <= rows_n;
                tile_out_base <= plane_acc_n + row_off_n;
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: tile-list model built from the layer geometry,
// per-cycle control/tile comparison, plus hand-computed literal checks.
module tb_conv_tile_scheduler;

    localparam int OCT = 8;
    localparam int RT  = 4;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, eng_done = 1'b0;
    logic [2:0]  K = '0, STRIDE = '0;
    logic [13:0] IC = '0;
    logic [5:0]  IMG_H = '0, IMG_W = '0;
    logic [7:0]  OC = '0;
    logic        busy, done, err, eng_start;
    logic [7:0]  tile_oc_base;
    logic [6:0]  tile_oc_cnt;
    logic [5:0]  tile_row_base, tile_rows;
    logic [17:0] tile_out_base;
    logic [11:0] tiles_done;

    conv_tile_scheduler #(.OC_TILE(OCT), .ROW_TILE(RT)) dut (
        .clk(clk), .rst(rst), .start(start), .K(K), .IC(IC), .IMG_H(IMG_H), .IMG_W(IMG_W),
        .OC(OC), .STRIDE(STRIDE), .busy(busy), .done(done), .err(err),
        .eng_start(eng_start), .eng_done(eng_done), .tile_oc_base(tile_oc_base),
        .tile_oc_cnt(tile_oc_cnt), .tile_row_base(tile_row_base), .tile_rows(tile_rows),
        .tile_out_base(tile_out_base), .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    typedef struct {int ocb; int occ; int rb; int rows; int ob;} tile_t;
    tile_t tq[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit m_busy = 0, m_wait = 0, m_in_tile = 0, m_zero = 1, m_err = 0;
    int exp_es = -10, exp_done = -10, t_idx = 0;
    int obs_ob[64], obs_rows[64], obs_ocb[64], obs_occ[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Full tile list of a layer, straight from the geometry formulas.
    function automatic bit build_tiles(input int k, ic, h, w, oc, s);
        int oh, ow, plane, sh;
        tile_t t;
        tq.delete();
        if (k == 0 || k > h || k > w || oc == 0 || ic == 0 || (s != 1 && s != 2)) return 1'b0;
        sh    = (s == 2) ? 1 : 0;
        oh    = ((h - k) >> sh) + 1;
        ow    = ((w - k) >> sh) + 1;
        plane = oh * ow;
        for (int ocb = 0; ocb < oc; ocb += OCT) begin
            for (int rb = 0; rb < oh; rb += RT) begin
                t.ocb  = ocb;
                t.occ  = (oc - ocb < OCT) ? oc - ocb : OCT;
                t.rb   = rb;
                t.rows = (oh - rb < RT) ? oh - rb : RT;
                t.ob   = (ocb * plane + rb * ow) % 262144;
                tq.push_back(t);
            end
        end
        return 1'b1;
    endfunction

    // Event model: start at edge t -> first issue visible after edge t+1;
    // accepted eng_done at edge u -> next issue / done visible after edge u+1.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0; m_wait = 0; m_in_tile = 0; m_zero = 1;
            exp_es = -10; exp_done = -10;
        end else begin
            m_zero = 0;
            if (!m_busy && start) begin
                m_busy = 1;
                t_idx  = 0;
                if (build_tiles(int'(K), int'(IC), int'(IMG_H), int'(IMG_W), int'(OC),
                                int'(STRIDE))) begin
                    exp_es = cyc + 1; m_err = 0;
                end else begin
                    exp_done = cyc + 1; m_err = 1;
                end
            end
            if (m_wait && eng_done) begin
                m_wait = 0; m_in_tile = 0; t_idx++;
                if (t_idx < tq.size()) exp_es = cyc + 1;
                else exp_done = cyc + 1;
            end
            if (cyc == exp_es) m_in_tile = 1;
            if (cyc == exp_es + 1) m_wait = 1;
            if (cyc == exp_done + 1) m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (m_zero) begin
            check("reset_outputs", {busy, done, err, eng_start, tile_oc_base, tile_oc_cnt,
                  tile_row_base, tile_rows, tile_out_base, tiles_done}, 64'd0);
        end else begin
            check("ctrl busy/done/err/eng_start", {busy, done, err, eng_start},
                  {m_busy, cyc == exp_done, (cyc == exp_done) && m_err, cyc == exp_es});
            if (m_in_tile && t_idx < tq.size())
                check("tile_fields", {tile_oc_base, tile_oc_cnt, tile_row_base, tile_rows,
                      tile_out_base}, {8'(tq[t_idx].ocb), 7'(tq[t_idx].occ),
                      6'(tq[t_idx].rb), 6'(tq[t_idx].rows), 18'(tq[t_idx].ob)});
            if (cyc == exp_es) check("tiles_done_at_issue", 64'(tiles_done), 64'(t_idx));
            if (cyc == exp_done && !m_err)
                check("tiles_done_at_end", 64'(tiles_done), 64'(tq.size()));
        end
    end

    // Drives one layer and acts as the engine; optionally injects ignored noise
    // or asserts reset in the WAIT of tile rst_tile.
    task automatic run_layer(input int k, ic, h, w, oc, s, ack, input bit noise,
                             input int rst_tile, output int nes, output bit got_err);
        bit fin = 0;
        int cnt = -1;
        nes = 0;
        got_err = 0;
        @(negedge clk);
        K = 3'(k); IC = 14'(ic); IMG_H = 6'(h); IMG_W = 6'(w); OC = 8'(oc); STRIDE = 3'(s);
        start = 1'b1;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            eng_done = 1'b0;
            if (done) begin
                fin = 1;
                got_err = err;
            end else if (eng_start) begin
                if (nes < 64) begin
                    obs_ob[nes] = int'(tile_out_base); obs_rows[nes] = int'(tile_rows);
                    obs_ocb[nes] = int'(tile_oc_base); obs_occ[nes] = int'(tile_oc_cnt);
                end
                if (nes == rst_tile) begin
                    @(negedge clk);
                    rst = 1'b1;
                    repeat (3) @(negedge clk);
                    rst = 1'b0;
                    nes++;
                    return;
                end
                nes++;
                cnt = ack;
                if (noise) eng_done = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    if (noise) start = 1'b1;
                end else if (noise && cnt == 2) begin
                    start = 1'b1;
                end
            end
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL layer_timeout: no done within bound, tiles issued %0d", nes);
        end
    endtask

    int nes;
    bit ge;
    int bad_cfg[4][6] = '{'{0, 8, 32, 32, 16, 1}, '{7, 8, 6, 32, 16, 1},
                          '{3, 8, 32, 32, 16, 3}, '{3, 8, 32, 32, 0, 1}};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_layer(3, 8, 32, 32, 16, 1, 5, 0, -1, nes, ge);
        check("l1_tiles", 64'(nes), 64'd16);
        check("l1_err", 64'(ge), 64'd0);
        check("l1_t7_rows", 64'(obs_rows[7]), 64'd2);
        check("l1_t7_out_base", 64'(obs_ob[7]), 64'd840);
        check("l1_t8_oc_base", 64'(obs_ocb[8]), 64'd8);
        check("l1_t8_out_base", 64'(obs_ob[8]), 64'd7200);

        run_layer(1, 16, 32, 32, 32, 1, 2, 0, -1, nes, ge);
        check("l2_tiles", 64'(nes), 64'd32);
        check("l2_last_out_base", 64'(obs_ob[31]), 64'd25472);
        check("l2_last_rows", 64'(obs_rows[31]), 64'd4);
        check("l2_last_oc_cnt", 64'(obs_occ[31]), 64'd8);

        run_layer(3, 8, 32, 32, 12, 2, 3, 0, -1, nes, ge);
        check("l3_tiles", 64'(nes), 64'd8);
        check("l3_t3_rows", 64'(obs_rows[3]), 64'd3);
        check("l3_t4_oc_cnt", 64'(obs_occ[4]), 64'd4);
        check("l3_t4_out_base", 64'(obs_ob[4]), 64'd1800);

        for (int i = 0; i < 4; i++) begin
            run_layer(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], bad_cfg[i][3],
                      bad_cfg[i][4], bad_cfg[i][5], 2, 0, -1, nes, ge);
            check("bad_cfg_no_issue", 64'(nes), 64'd0);
            check("bad_cfg_err", 64'(ge), 64'd1);
        end

        // Stray engine acks while idle, then noisy handshakes during a layer.
        @(negedge clk); eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        run_layer(3, 8, 32, 32, 12, 2, 4, 1, -1, nes, ge);
        check("noise_tiles", 64'(nes), 64'd8);
        check("noise_t4_out_base", 64'(obs_ob[4]), 64'd1800);
        check("noise_t3_rows", 64'(obs_rows[3]), 64'd3);

        run_layer(3, 8, 32, 32, 16, 1, 5, 0, 3, nes, ge);
        check("rst_abort_tiles", 64'(nes), 64'd4);
        run_layer(3, 8, 32, 32, 16, 1, 3, 0, -1, nes, ge);
        check("restart_tiles", 64'(nes), 64'd16);
        check("restart_t0_out_base", 64'(obs_ob[0]), 64'd0);
        check("restart_t15_out_base", 64'(obs_ob[15]), 64'd8040);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
